// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and RX state encodings
package uart_pkg;

   localparam int UART_PRESC_W = 21;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop synchronizer for async inputs, resets to 1 (idle)
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff <= '1;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and runtime prescaler
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic                    RX,
   input  logic [UART_PRESC_W-1:0] prescaler_in,
   output logic [7:0]              data,
   output logic                    rx_valid,
   output logic                    rx_frame_err,
   output logic                    rx_active
);

   localparam logic [UART_PRESC_W-1:0] PRESC_ONE = 1;

   logic                    rxs;
   rx_state_e               state;
   logic [UART_PRESC_W-1:0] presc;
   logic [UART_PRESC_W-1:0] cnt;
   logic [7:0]              shreg;
   logic [2:0]              bit_idx;

   uart_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (CLK),
      .rst_n(rst_n),
      .d    (RX),
      .q    (rxs)
   );

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         presc        <= '0;
         cnt          <= '0;
         shreg        <= 8'h00;
         bit_idx      <= 3'd0;
         data         <= 8'h00;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_active    <= 1'b0;
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  // Half-bit offset puts every later sample at mid-bit
                  presc     <= prescaler_in;
                  cnt       <= (prescaler_in >> 1) - PRESC_ONE;
                  state     <= ST_START;
                  rx_active <= 1'b1;
               end
            end
            ST_START: begin
               if (cnt == '0) begin
                  cnt <= presc - PRESC_ONE;
                  if (rxs) begin
                     state     <= ST_IDLE;
                     rx_active <= 1'b0;
                  end else begin
                     state   <= ST_DATA;
                     bit_idx <= 3'd0;
                  end
               end else begin
                  cnt <= cnt - PRESC_ONE;
               end
            end
            ST_DATA: begin
               if (cnt == '0) begin
                  shreg   <= {rxs, shreg[7:1]};
                  cnt     <= presc - PRESC_ONE;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end
               end else begin
                  cnt <= cnt - PRESC_ONE;
               end
            end
            ST_STOP: begin
               if (cnt == '0) begin
                  if (rxs) begin
                     data      <= shreg;
                     rx_valid  <= 1'b1;
                     state     <= ST_IDLE;
                     rx_active <= 1'b0;
                  end else begin
                     rx_frame_err <= 1'b1;
                     state        <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt - PRESC_ONE;
               end
            end
            ST_BREAK: begin
               // A held-low line reports one error, not a stream of frames
               if (rxs) begin
                  state     <= ST_IDLE;
                  rx_active <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with scoreboarded frames
module tb_uart_rx;

   localparam int SYNC = 2;

   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic [20:0] prescaler_in = 21'd16;
   logic [7:0]  data;
   logic        rx_valid;
   logic        rx_frame_err;
   logic        rx_active;

   uart_rx #(
      .SYNC_STAGES(SYNC)
   ) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .RX          (RX),
      .prescaler_in(prescaler_in),
      .data        (data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_active   (rx_active)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0]  d;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   logic        rst_q = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          n_total = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_ferr = 0;
   int          n_inv = 0;

   always @(posedge CLK) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (rx_valid && rx_frame_err) n_inv++;
      if (rst_q && !rx_valid && data !== prev_data) n_inv++;
      prev_data = data;
      if (rx_frame_err) n_ferr++;
      if (rx_valid) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rx_data", data, e.d);
            check("pulse_cycle", cyc, e.at);
         end
      end
   end

   // rst_bit/chg_bit index the 10-bit frame (0 = start bit); -1 disables
   task automatic send(input logic [7:0] b, input int p, input bit stop_ok, input bit expect_ok,
                       input int rst_bit, input int chg_bit, input int new_p);
      logic [9:0] f;
      bit         did_rst;
      f = {stop_ok, b, 1'b0};
      @(negedge CLK);
      prescaler_in = p[20:0];
      if (expect_ok) sb.push_back('{b, cyc + 1 + SYNC + p / 2 + 9 * p});
      for (int i = 0; i < 10; i++) begin
         RX = f[i];
         for (int c = 0; c < p; c++) begin
            did_rst = 0;
            if (i == chg_bit && c == 0) prescaler_in = new_p[20:0];
            if (i == rst_bit && c == p / 2) begin
               rst_n   = 1'b0;
               did_rst = 1;
            end
            @(negedge CLK);
            if (did_rst) begin
               rst_n = 1'b1;
               check("rst_data", data, 8'h00);
               check("rst_valid", rx_valid, 1'b0);
               check("rst_ferr", rx_frame_err, 1'b0);
               check("rst_active", rx_active, 1'b0);
            end
         end
      end
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge CLK);
      check("drain_empty", sb.size(), 0);
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lb[4];
      lb = '{8'h00, 8'hFF, 8'hA5, 8'h3C};

      rst_n = 1'b0;
      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
      check("reset_data", data, 8'h00);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_ferr", rx_frame_err, 1'b0);
      check("reset_active", rx_active, 1'b0);
      repeat (5) @(negedge CLK);

      send(8'h55, 16, 1, 1, -1, -1, 0);
      drain(100);
      check("good55_ferr", n_ferr, 0);

      for (int k = 0; k < 4; k++) send(lb[k], 104, 1, 1, -1, -1, 0);
      drain(200);
      check("b2b_ferr", n_ferr, 0);

      prescaler_in = 21'd16;
      @(negedge CLK);
      RX = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (i == 2) check("fs_active_high", rx_active, 1'b1);
      end
      RX = 1'b1;
      repeat (8) @(negedge CLK);
      check("fs_active_low", rx_active, 1'b0);
      repeat (20) @(negedge CLK);
      check("fs_ferr", n_ferr, 0);
      send(8'h81, 16, 1, 1, -1, -1, 0);
      drain(100);

      send(8'h42, 16, 0, 0, -1, -1, 0);
      repeat (40) @(negedge CLK);
      RX = 1'b1;
      repeat (20) @(negedge CLK);
      check("fe_count", n_ferr, 1);
      check("fe_data_kept", data, 8'h81);
      check("fe_active_low", rx_active, 1'b0);
      send(8'h24, 16, 1, 1, -1, -1, 0);
      drain(100);

      send(8'hF0, 16, 1, 0, 5, -1, 0);
      repeat (30) @(negedge CLK);
      check("abort_data", data, 8'h00);
      send(8'h0F, 16, 1, 1, -1, -1, 0);
      drain(100);

      send(8'hA7, 16, 1, 1, -1, 3, 32);
      send(8'h5A, 32, 1, 1, -1, -1, 0);
      drain(200);

      send(8'hC3, 4, 1, 1, -1, -1, 0);
      send(8'h3C, 5, 1, 1, -1, -1, 0);
      drain(100);

      check("final_ferr", n_ferr, 1);
      check("invariants", n_inv, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
